// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared types and constants for the SM3 message padder
package sm3_pkg;

  localparam int SM3_LEN_W      = 64;
  localparam int SM3_BLK_W      = 512;
  localparam int SM3_INPT_DW_32 = 32;
  localparam int SM3_INPT_DW_64 = 64;

  typedef enum logic [1:0] {
    S_DATA,
    S_ZERO,
    S_LEN
  } sm3_pad_st_t;

  // Bits carried by the final word: 8 * (byte_num + 1)
  function automatic logic [SM3_LEN_W-1:0] sm3_lst_bits(input logic [2:0] byte_num);
    return ({61'd0, byte_num} + 64'd1) << 3;
  endfunction

endpackage

// File: rtl/sm3_pad_lst_wd.sv
// rtl/sm3_pad_lst_wd.sv - masks bytes past the message end and inserts 0x80
module sm3_pad_lst_wd
  import sm3_pkg::*;
#(
  parameter  int DW  = SM3_INPT_DW_32,
  localparam int NB  = DW / 8,
  localparam int BNW = $clog2(NB)
) (
  input  logic [DW-1:0]  din,
  input  logic [BNW-1:0] byte_num,
  output logic [DW-1:0]  dout,
  output logic           pad80_ins
);

  // Byte 0 sits in the MSBs; bytes 0..byte_num are message, byte_num+1 is the marker
  always_comb begin
    dout = '0;
    for (int i = 0; i < NB; i++) begin
      if (i <= int'(byte_num)) begin
        dout[DW-1-8*i -: 8] = din[DW-1-8*i -: 8];
      end else if (i == int'(byte_num) + 1) begin
        dout[DW-1-8*i -: 8] = 8'h80;
      end
    end
  end

  assign pad80_ins = (int'(byte_num) < NB - 1);

endmodule

// File: rtl/sm3_msg_pad.sv
// rtl/sm3_msg_pad.sv - SM3 message padder: data pass-through, 0x80/zero fill, 64-bit length
module sm3_msg_pad
  import sm3_pkg::*;
#(
  parameter  int DW  = SM3_INPT_DW_32,
  localparam int BNW = $clog2(DW / 8)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inpt_vld,
  output logic           inpt_rdy,
  input  logic [DW-1:0]  inpt_d,
  input  logic           inpt_lst,
  input  logic [BNW-1:0] inpt_byte_num,
  output logic           pad_otpt_vld,
  input  logic           pad_otpt_rdy,
  output logic [DW-1:0]  pad_otpt_d,
  output logic           pad_otpt_lst
);

  localparam int WPB    = SM3_BLK_W / DW;
  localparam int LEN_IX = WPB - SM3_LEN_W / DW;
  localparam int IW     = $clog2(WPB);
  localparam logic [IW-1:0] LEN_IX_I = IW'(LEN_IX);
  localparam logic [IW-1:0] LAST_I   = IW'(WPB - 1);

  sm3_pad_st_t          st_q, st_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [SM3_LEN_W-1:0] bit_len_q, bit_len_d;
  logic                 pad80_q, pad80_d;

  logic [DW-1:0]        lst_wd;
  logic                 pad80_ins;
  logic [SM3_LEN_W-1:0] len_sh;
  logic                 pad_vld, pad_lst, rdy, hs;
  logic [DW-1:0]        pad_d;

  sm3_pad_lst_wd #(.DW(DW)) u_lst_wd (
    .din       (inpt_d),
    .byte_num  (inpt_byte_num),
    .dout      (lst_wd),
    .pad80_ins (pad80_ins)
  );

  always_comb begin
    pad_vld = 1'b0;
    pad_d   = '0;
    pad_lst = 1'b0;
    rdy     = 1'b0;
    len_sh  = '0;
    case (st_q)
      S_DATA: begin
        pad_vld = inpt_vld;
        rdy     = pad_otpt_rdy;
        pad_d   = inpt_lst ? lst_wd : inpt_d;
      end
      S_ZERO: begin
        pad_vld = 1'b1;
        pad_d   = pad80_q ? '0 : {8'h80, {(DW-8){1'b0}}};
      end
      S_LEN: begin
        // Length words go out high word first, so shift the wanted word to the top
        pad_vld = 1'b1;
        len_sh  = bit_len_q << (DW * (int'(idx_q) - LEN_IX));
        pad_d   = len_sh[SM3_LEN_W-1 -: DW];
        pad_lst = (idx_q == LAST_I);
      end
      default: ;
    endcase
  end

  assign hs           = pad_vld & pad_otpt_rdy;
  assign inpt_rdy     = rdy;
  assign pad_otpt_vld = pad_vld & ~rst;
  assign pad_otpt_d   = rst ? '0 : pad_d;
  assign pad_otpt_lst = pad_lst & ~rst;

  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    bit_len_d = bit_len_q;
    pad80_d   = pad80_q;
    if (hs) begin
      idx_d = (idx_q == LAST_I) ? '0 : idx_q + IW'(1);
      case (st_q)
        S_DATA: begin
          if (inpt_lst) begin
            bit_len_d = bit_len_q + sm3_lst_bits(3'(inpt_byte_num));
            pad80_d   = pad80_q | pad80_ins;
            st_d      = (pad80_d && idx_d == LEN_IX_I) ? S_LEN : S_ZERO;
          end else begin
            bit_len_d = bit_len_q + 64'(DW);
          end
        end
        S_ZERO: begin
          pad80_d = 1'b1;
          if (idx_d == LEN_IX_I) st_d = S_LEN;
        end
        S_LEN: begin
          if (idx_q == LAST_I) begin
            st_d      = S_DATA;
            bit_len_d = '0;
            pad80_d   = 1'b0;
            idx_d     = '0;
          end
        end
        default: st_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_DATA;
      idx_q     <= '0;
      bit_len_q <= '0;
      pad80_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      idx_q     <= idx_d;
      bit_len_q <= bit_len_d;
      pad80_q   <= pad80_d;
    end
  end

endmodule

// File: tb/tb_sm3_msg_pad.sv
// tb/tb_sm3_msg_pad.sv - directed bench for sm3_msg_pad (DW=32 and DW=64 instances)
module tb_sm3_msg_pad;
  import sm3_pkg::*;

  typedef logic [31:0] w32_q_t[$];
  typedef logic [63:0] w64_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        inpt_vld, inpt_rdy, inpt_lst, pad_otpt_vld, pad_otpt_rdy, pad_otpt_lst;
  logic [31:0] inpt_d, pad_otpt_d;
  logic [1:0]  inpt_byte_num;

  logic        i64_vld, i64_rdy, i64_lst, o64_vld, o64_rdy, o64_lst;
  logic [63:0] i64_d, o64_d;
  logic [2:0]  i64_bn;

  int n_chk  = 0;
  int n_fail = 0;

  sm3_msg_pad #(.DW(SM3_INPT_DW_32)) dut (
    .clk(clk), .rst(rst),
    .inpt_vld(inpt_vld), .inpt_rdy(inpt_rdy), .inpt_d(inpt_d), .inpt_lst(inpt_lst),
    .inpt_byte_num(inpt_byte_num),
    .pad_otpt_vld(pad_otpt_vld), .pad_otpt_rdy(pad_otpt_rdy),
    .pad_otpt_d(pad_otpt_d), .pad_otpt_lst(pad_otpt_lst)
  );

  sm3_msg_pad #(.DW(SM3_INPT_DW_64)) dut64 (
    .clk(clk), .rst(rst),
    .inpt_vld(i64_vld), .inpt_rdy(i64_rdy), .inpt_d(i64_d), .inpt_lst(i64_lst),
    .inpt_byte_num(i64_bn),
    .pad_otpt_vld(o64_vld), .pad_otpt_rdy(o64_rdy),
    .pad_otpt_d(o64_d), .pad_otpt_lst(o64_lst)
  );

  function automatic w32_q_t mk_msg(input int nw, input logic [31:0] lastw);
    w32_q_t m;
    for (int i = 0; i < nw - 1; i++) m.push_back(32'h61626364);
    m.push_back(lastw);
    return m;
  endfunction

  function automatic w32_q_t mk_exp(input int ntot, input int ndata,
                                    input logic [31:0] padw, input logic [31:0] lenw);
    w32_q_t e;
    for (int i = 0; i < ntot; i++) e.push_back((i < ndata) ? 32'h61626364 : 32'h0);
    e[ndata]  = padw;
    e[ntot-1] = lenw;
    return e;
  endfunction

  task automatic scn(input int s, output w32_q_t m, output logic [1:0] bn, output w32_q_t e);
    case (s)
      0:       begin m = mk_msg(1,  32'h61626300); bn = 2'd2; e = mk_exp(16, 0,  32'h61626380, 32'h18);  end
      1:       begin m = mk_msg(14, 32'h61626300); bn = 2'd2; e = mk_exp(16, 13, 32'h61626380, 32'h1B8); end
      2:       begin m = mk_msg(14, 32'h61626364); bn = 2'd3; e = mk_exp(32, 14, 32'h80000000, 32'h1C0); end
      default: begin m = mk_msg(16, 32'h61626364); bn = 2'd3; e = mk_exp(32, 16, 32'h80000000, 32'h200); end
    endcase
  endtask

  task automatic run32(input w32_q_t msg, input logic [1:0] lbn, input bit gaps,
                       output w32_q_t got, output int rdy_viol, output int hold_viol,
                       output bit timeout);
    int wi, cyc;
    bit cur_vld, done, last_acc, prev_stall;
    logic [31:0] prev_d;
    wi = 0; cyc = 0; cur_vld = 0; done = 0; last_acc = 0; prev_stall = 0; prev_d = '0;
    got = {}; rdy_viol = 0; hold_viol = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!cur_vld && wi < msg.size()) cur_vld = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      inpt_vld = cur_vld;
      inpt_d   = 32'h0;
      if (cur_vld) inpt_d = msg[wi];
      inpt_lst      = cur_vld && (wi == msg.size() - 1);
      inpt_byte_num = inpt_lst ? lbn : 2'($urandom_range(0, 3));
      pad_otpt_rdy  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (prev_stall && (!pad_otpt_vld || pad_otpt_d !== prev_d)) hold_viol++;
      if (last_acc && inpt_rdy) rdy_viol++;
      if (pad_otpt_vld && pad_otpt_rdy) begin
        got.push_back(pad_otpt_d);
        if (pad_otpt_lst) done = 1;
      end
      if (inpt_vld && inpt_rdy) begin
        wi++;
        cur_vld = 0;
        if (wi == msg.size()) last_acc = 1;
      end
      prev_stall = pad_otpt_vld && !pad_otpt_rdy;
      prev_d     = pad_otpt_d;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inpt_vld = 0; inpt_d = '0; inpt_lst = 0; inpt_byte_num = '0; pad_otpt_rdy = 1;
    i64_vld = 0; i64_d = '0; i64_lst = 0; i64_bn = '0; o64_rdy = 1;
    @(negedge clk); #1;
    n_chk++; if (pad_otpt_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", pad_otpt_vld); end
    n_chk++; if (pad_otpt_d !== 32'h0) begin n_fail++; $display("FAIL reset_d: got %h expected 0", pad_otpt_d); end
    n_chk++; if (pad_otpt_lst !== 1'b0) begin n_fail++; $display("FAIL reset_lst: got %b expected 0", pad_otpt_lst); end
    n_chk++; if (inpt_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_hi: got %b expected 1", inpt_rdy); end
    n_chk++; if (o64_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld64: got %b expected 0", o64_vld); end
    pad_otpt_rdy = 0; #1;
    n_chk++; if (inpt_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_lo: got %b expected 0", inpt_rdy); end
    @(negedge clk); rst = 1'b0;
  endtask

  // Output-stalled last words exercise the masking with no handshake taking place
  task automatic test_last_word_mask();
    logic [1:0]  bns [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] exps[4] = '{32'hAA800000, 32'hAABB8000, 32'hAABBCC80, 32'hAABBCCDD};
    @(negedge clk);
    pad_otpt_rdy = 0; inpt_vld = 1; inpt_lst = 0; inpt_d = 32'h12345678; inpt_byte_num = 2'd1; #1;
    n_chk++; if (pad_otpt_vld !== 1'b1 || pad_otpt_d !== 32'h12345678) begin
      n_fail++; $display("FAIL passthru: got vld=%b d=%h expected vld=1 d=12345678", pad_otpt_vld, pad_otpt_d);
    end
    inpt_lst = 1; inpt_d = 32'hAABBCCDD;
    for (int i = 0; i < 4; i++) begin
      inpt_byte_num = bns[i]; #1;
      n_chk++; if (pad_otpt_d !== exps[i]) begin
        n_fail++; $display("FAIL mask_bn%0d: got %h expected %h", i, pad_otpt_d, exps[i]);
      end
    end
    @(negedge clk); inpt_vld = 0; inpt_lst = 0;
  endtask

  task automatic test_pad_vectors(input int s_lo, input int s_hi, input bit gaps);
    w32_q_t m, e, got;
    logic [1:0] bn;
    int rv, hv;
    bit to;
    for (int s = s_lo; s <= s_hi; s++) begin
      scn(s, m, bn, e);
      run32(m, bn, gaps, got, rv, hv, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL T%0d_g%0d_timeout: got no lst expected lst", s + 1, gaps); end
      n_chk++; if (got.size() != e.size()) begin
        n_fail++; $display("FAIL T%0d_g%0d_count: got %0d expected %0d", s + 1, gaps, got.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < got.size(); i++) begin
        n_chk++; if (got[i] !== e[i]) begin
          n_fail++; $display("FAIL T%0d_g%0d_w%0d: got %h expected %h", s + 1, gaps, i, got[i], e[i]);
        end
      end
      n_chk++; if (rv != 0) begin n_fail++; $display("FAIL T%0d_g%0d_rdy_in_pad: got %0d cycles expected 0", s + 1, gaps, rv); end
      n_chk++; if (hv != 0) begin n_fail++; $display("FAIL T%0d_g%0d_stall_hold: got %0d changes expected 0", s + 1, gaps, hv); end
    end
  endtask

  task automatic test_dw64();
    w64_q_t got;
    bit done = 0, sent = 0;
    int cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk); cyc++;
      i64_vld = !sent; i64_lst = !sent; i64_bn = 3'd2; i64_d = 64'h6162630000000000; o64_rdy = 1;
      #1;
      if (o64_vld && o64_rdy) begin got.push_back(o64_d); if (o64_lst) done = 1; end
      if (i64_vld && i64_rdy) sent = 1;
    end
    @(negedge clk); i64_vld = 0; i64_lst = 0;
    n_chk++; if (got.size() != 8) begin n_fail++; $display("FAIL T6_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      logic [63:0] ex;
      ex = (i == 0) ? 64'h6162638000000000 : (i == 7) ? 64'h18 : 64'h0;
      n_chk++; if (got[i] !== ex) begin n_fail++; $display("FAIL T6_w%0d: got %h expected %h", i, got[i], ex); end
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    pad_otpt_rdy = 1; inpt_vld = 1; inpt_lst = 1; inpt_byte_num = 2'd2; inpt_d = 32'h61626300;
    @(negedge clk);
    inpt_vld = 0; inpt_lst = 0; inpt_d = '0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (pad_otpt_vld !== 1'b1 || pad_otpt_d !== 32'h0 || inpt_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_zero_state: got vld=%b d=%h rdy=%b expected vld=1 d=0 rdy=0", pad_otpt_vld, pad_otpt_d, inpt_rdy);
    end
    #1 rst = 1'b1;
    #1;
    n_chk++; if (pad_otpt_vld !== 1'b0 || inpt_rdy !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_out: got vld=%b rdy=%b expected vld=0 rdy=1", pad_otpt_vld, inpt_rdy);
    end
    @(negedge clk); rst = 1'b0;
    test_pad_vectors(0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_last_word_mask();
    test_pad_vectors(0, 1, 1'b0);
    test_pad_vectors(2, 3, 1'b0);
    test_pad_vectors(0, 3, 1'b1);
    test_dw64();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
